// File: rtl/trap_filter_ctrl.sv
// trap_filter_ctrl
// Sequencing for a trapezoidal shaping filter. The block holds the active
// k/l/M coefficient set and accepts new sets from the host through a
// write/ready handshake, rejecting illegal ones. An accepted set is applied
// atomically. The filter delay line is then cleared for CLR_CYCLES clocks.
// The filter output is held invalid until k_act+l_act new samples have
// refilled the delay line.
module trap_filter_ctrl #(
  parameter int K_W        = 8,
  parameter int M_W        = 16,
  parameter int MAX_DEPTH  = 128,
  parameter int DEF_K      = 4,
  parameter int DEF_L      = 8,
  parameter int DEF_M      = 100,
  parameter int CLR_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,      // asynchronous, active-low
  input  logic           adc_valid,
  input  logic [K_W-1:0] cfg_k,
  input  logic [K_W-1:0] cfg_l,
  input  logic [M_W-1:0] cfg_m,
  input  logic           cfg_wr,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic [K_W-1:0] k_act,
  output logic [K_W-1:0] l_act,
  output logic [M_W-1:0] m_act,
  output logic           filt_clr,
  output logic           filt_en,
  output logic           out_valid,
  output logic [1:0]     state_o
);

  // Sums of two K_W-bit coefficients are formed one bit wider so they
  // cannot wrap.
  localparam int SUM_W = K_W + 1;
  localparam int CNT_W = $clog2(MAX_DEPTH + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(MAX_DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_APPLY  = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_WARMUP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [CLR_W-1:0] w_clr_cnt_nxt;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] w_smp_cnt_nxt;

  // Shadow set: written by an accepted legal host write, copied to the
  // active set during APPLY.
  logic [K_W-1:0]   r_shd_k;
  logic [K_W-1:0]   r_shd_l;
  logic [M_W-1:0]   r_shd_m;

  // Active set driven to the filter datapath.
  logic [K_W-1:0]   r_k_act;
  logic [K_W-1:0]   r_l_act;
  logic [M_W-1:0]   r_m_act;

  // Registered control outputs.
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_filt_clr;
  logic             r_filt_en;
  logic             r_out_valid;

  // Decoded values of the control outputs for the next state.
  logic             w_ready_nxt;
  logic             w_clr_nxt;
  logic             w_en_nxt;
  logic             w_valid_nxt;

  // Legality of the requested set and the handshake qualifiers.
  logic [SUM_W-1:0] w_cfg_sum;
  logic             w_cfg_legal;
  logic             w_wr_accept;
  logic             w_wr_apply;
  logic             w_wr_reject;

  // Delay-line depth of the active set and warm-up completion.
  logic [SUM_W-1:0] w_act_depth;
  logic [SUM_W-1:0] w_smp_cnt_inc;
  logic             w_warm_done;

  // A set is legal when 1 <= k <= l and k + l fits in the delay line.
  assign w_cfg_sum   = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign w_cfg_legal = (cfg_k != '0) && (cfg_k <= cfg_l) && (w_cfg_sum <= MAX_SUM);

  // A write happens only when the host strobes while ready is high.
  // Otherwise the strobe is ignored.
  assign w_wr_accept = cfg_wr && r_cfg_ready;
  assign w_wr_apply  = w_wr_accept && w_cfg_legal;
  assign w_wr_reject = w_wr_accept && !w_cfg_legal;

  // The strobe being counted now is the last one needed to fill the line.
  assign w_act_depth   = {1'b0, r_k_act} + {1'b0, r_l_act};
  assign w_smp_cnt_inc = SUM_W'(r_smp_cnt) + SUM_W'(1);
  assign w_warm_done   = (w_smp_cnt_inc >= w_act_depth);

  // Next-state and counter logic for the apply/clear/warm-up sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_smp_cnt_nxt = r_smp_cnt;

    unique case (r_state)
      ST_RUN: begin
        if (w_wr_apply) begin
          w_state_nxt = ST_APPLY;
        end
      end

      ST_APPLY: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end

      ST_CLEAR: begin
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = ST_WARMUP;
          w_smp_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
        end
      end

      ST_WARMUP: begin
        // A new legal set takes priority over a completing warm-up.
        if (w_wr_apply) begin
          w_state_nxt = ST_APPLY;
        end else if (adc_valid) begin
          if (w_warm_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_smp_cnt_nxt = r_smp_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Decode the control outputs from the next state so they can be registered.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_clr_nxt   = 1'b0;
    w_en_nxt    = 1'b0;
    w_valid_nxt = 1'b0;
    unique case (w_state_nxt)
      ST_RUN: begin
        w_ready_nxt = 1'b1;
        w_en_nxt    = 1'b1;
        w_valid_nxt = 1'b1;
      end
      ST_APPLY: begin
        w_ready_nxt = 1'b0;
      end
      ST_CLEAR: begin
        w_clr_nxt = 1'b1;
      end
      ST_WARMUP: begin
        w_ready_nxt = 1'b1;
        w_en_nxt    = 1'b1;
      end
      default: begin
        w_clr_nxt = 1'b1;
      end
    endcase
  end

  // State register and sequencing counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_smp_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge, independent of
      // statement order.
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_smp_cnt <= w_smp_cnt_nxt;
    end
  end

  // Capture the requested set into the shadow registers on a legal write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shd_k <= K_W'(DEF_K);
      r_shd_l <= K_W'(DEF_L);
      r_shd_m <= M_W'(DEF_M);
    end else if (w_wr_apply) begin
      r_shd_k <= cfg_k;
      r_shd_l <= cfg_l;
      r_shd_m <= cfg_m;
    end
  end

  // The active set changes only at the end of the APPLY cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k_act <= K_W'(DEF_K);
      r_l_act <= K_W'(DEF_L);
      r_m_act <= M_W'(DEF_M);
    end else if (r_state == ST_APPLY) begin
      r_k_act <= r_shd_k;
      r_l_act <= r_shd_l;
      r_m_act <= r_shd_m;
    end
  end

  // Registered control outputs. The reset values match the CLEAR state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_ready <= 1'b0;
      r_filt_clr  <= 1'b1;
      r_filt_en   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_cfg_ready <= w_ready_nxt;
      r_filt_clr  <= w_clr_nxt;
      r_filt_en   <= w_en_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

  // Single-cycle error pulse after a rejected write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_wr_reject;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign k_act     = r_k_act;
  assign l_act     = r_l_act;
  assign m_act     = r_m_act;
  assign filt_clr  = r_filt_clr;
  assign filt_en   = r_filt_en;
  assign out_valid = r_out_valid;
  assign state_o   = r_state;

endmodule
